// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable/divided-level generator; ratio changes land on the target's period boundary.
// Outputs decode registered counters; cfg_ready is low outside LOCKED, so requests wait while settling or pending.
module clk_div_gen #(
   parameter int CH_NUM      = 5,
   parameter int DIV_W       = 10,
   parameter int INIT_RATIO  = 5,
   parameter int INIT_DUTY   = 2,
   parameter int INIT_PHASE  = 0,
   parameter int LOCK_CYCLES = 16,
   localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
   input  logic              clkin1,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_ratio,
   input  logic [DIV_W-1:0]  cfg_duty,
   input  logic [DIV_W-1:0]  cfg_phase,
   input  logic              load_phase,
   output logic [CH_NUM-1:0] clk_en,
   output logic [CH_NUM-1:0] clk_lvl,
   output logic              div_lock
);

   localparam logic [1:0] ALIGN  = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] PEND   = 2'd2;
   localparam logic [1:0] LOCKED = 2'd3;
   localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   logic [1:0]       state_q, state_d;
   logic [SET_W-1:0] scnt_q;
   logic             locked_q;

   logic [DIV_W-1:0] ratio_q [CH_NUM];
   logic [DIV_W-1:0] duty_q  [CH_NUM];
   logic [DIV_W-1:0] phase_q [CH_NUM];
   logic [DIV_W-1:0] cnt_q   [CH_NUM];

   logic [DIV_W-1:0] r_eff   [CH_NUM];
   logic [DIV_W-1:0] d_eff   [CH_NUM];
   logic [DIV_W-1:0] p_eff   [CH_NUM];
   logic [DIV_W-1:0] r_m1    [CH_NUM];
   logic [DIV_W-1:0] preload [CH_NUM];

   logic [CH_W-1:0]   pend_ch_q;
   logic [DIV_W-1:0]  pend_ratio_q, pend_duty_q, pend_phase_q;
   logic [CH_NUM-1:0] apply_vec;
   logic              hs, ch_ok, apply, running;

   assign hs        = cfg_valid & locked_q;
   assign ch_ok     = ({1'b0, cfg_ch} < (CH_W+1)'(CH_NUM));
   assign running   = (state_q != ALIGN);
   assign apply     = (state_q == PEND) && (|apply_vec);
   assign cfg_ready = locked_q;
   assign div_lock  = locked_q;

   always_comb begin
      clk_en    = '0;
      clk_lvl   = '0;
      apply_vec = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         r_eff[i]     = (ratio_q[i] == '0) ? DIV_W'(1) : ratio_q[i];
         d_eff[i]     = (duty_q[i] > r_eff[i]) ? r_eff[i] : duty_q[i];
         p_eff[i]     = (phase_q[i] >= r_eff[i]) ? r_eff[i] - DIV_W'(1) : phase_q[i];
         r_m1[i]      = r_eff[i] - DIV_W'(1);
         preload[i]   = (p_eff[i] == '0) ? '0 : r_eff[i] - p_eff[i];
         apply_vec[i] = (pend_ch_q == CH_W'(i)) && (cnt_q[i] == r_m1[i]);
         clk_en[i]    = running && (cnt_q[i] == '0);
         clk_lvl[i]   = running && (cnt_q[i] < d_eff[i]);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ALIGN:  state_d = SETTLE;
         SETTLE: begin
            if (load_phase)                             state_d = ALIGN;
            else if (scnt_q == SET_W'(LOCK_CYCLES - 1)) state_d = LOCKED;
         end
         LOCKED: begin
            if (load_phase)       state_d = ALIGN;
            else if (hs && ch_ok) state_d = PEND;
         end
         default: begin
            if (apply) state_d = SETTLE;
         end
      endcase
   end

   always_ff @(posedge clkin1) begin
      if (rst) begin
         state_q      <= ALIGN;
         scnt_q       <= '0;
         locked_q     <= 1'b0;
         pend_ch_q    <= '0;
         pend_ratio_q <= '0;
         pend_duty_q  <= '0;
         pend_phase_q <= '0;
         for (int i = 0; i < CH_NUM; i++) begin
            ratio_q[i] <= DIV_W'(INIT_RATIO);
            duty_q[i]  <= DIV_W'(INIT_DUTY);
            phase_q[i] <= DIV_W'(INIT_PHASE);
            cnt_q[i]   <= '0;
         end
      end else begin
         state_q  <= state_d;
         locked_q <= (state_d == LOCKED);
         scnt_q   <= (state_q == SETTLE) ? scnt_q + SET_W'(1) : '0;

         if (hs && ch_ok && !load_phase) begin
            pend_ch_q    <= cfg_ch;
            pend_ratio_q <= cfg_ratio;
            pend_duty_q  <= cfg_duty;
            pend_phase_q <= cfg_phase;
         end

         for (int i = 0; i < CH_NUM; i++) begin
            if (state_q == ALIGN) begin
               cnt_q[i] <= preload[i];
            end else if ((state_q == PEND) && apply_vec[i]) begin
               // New settings start on a fresh period; phase waits for the next realign.
               cnt_q[i]   <= '0;
               ratio_q[i] <= pend_ratio_q;
               duty_q[i]  <= pend_duty_q;
               phase_q[i] <= pend_phase_q;
            end else begin
               cnt_q[i] <= (cnt_q[i] >= r_m1[i]) ? '0 : cnt_q[i] + DIV_W'(1);
            end

            if (hs && ch_ok && load_phase && (cfg_ch == CH_W'(i))) begin
               ratio_q[i] <= cfg_ratio;
               duty_q[i]  <= cfg_duty;
               phase_q[i] <= cfg_phase;
            end
         end
      end
   end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Parametrised multi-channel clock-enable generator in the `clkin1` domain downstream of the board PLL (e.g. the 125 MHz ADC clock). Each channel derives an enable pulse and a divided level from a programmable ratio, duty and phase, mirroring the PLL output-divider model. Channels can be reconfigured at runtime through a valid/ready port, and all channels can be phase-realigned together. A lock indication reports when every channel is running on a stable configuration.

## Interface
- CH_NUM, 5, number of channels (1..8)
- DIV_W, 10, width of ratio/duty/phase fields
- INIT_RATIO, 5, ratio loaded into every channel on reset
- INIT_DUTY, 2, duty loaded into every channel on reset
- INIT_PHASE, 0, phase loaded into every channel on reset
- LOCK_CYCLES, 16, settle time in cycles before `div_lock` asserts (≥1)

Ports:
- clkin1  in  1  sole clock
- rst  in  1  reset: synchronous, active-high
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  configuration accepted when high together with `cfg_valid`
- cfg_ch  in  CH_W=max(1,$clog2(CH_NUM))  target channel
- cfg_ratio, cfg_duty, cfg_phase  in  DIV_W each  new settings
- load_phase  in  1  realign all channels
- clk_en  out  CH_NUM  one-cycle pulse per period, per channel
- clk_lvl  out  CH_NUM  divided waveform, per channel
- div_lock  out  1  all channels stable

## Operation
- Per channel, effective values:
  - r = max(ratio, 1)
  - d = min(duty, r)
  - p = (phase ≥ r) ? r−1 : phase
- Counter `cnt` runs 0..r−1 and wraps to 0.
- `clk_en` = (cnt==0); `clk_lvl` = (cnt < d). Both are decoded only from registers, never from inputs.
- FSM states: ALIGN, SETTLE, PEND, LOCKED.
- ALIGN (1 cycle):
  - Each counter is preloaded with (p==0 ? 0 : r−p).
  - `clk_en` and `clk_lvl` are forced to 0.
  - Next state is SETTLE.
- SETTLE:
  - Counters run.
  - A settle counter counts LOCK_CYCLES cycles, then the FSM goes to LOCKED.
- LOCKED:
  - `div_lock`=1 and `cfg_ready`=1.
  - A handshake with a valid `cfg_ch` (< CH_NUM) stores the request in a pending register and moves to PEND.
  - A handshake with `cfg_ch` ≥ CH_NUM is accepted and discarded; the FSM stays in LOCKED.
- PEND:
  - `cfg_ready`=0 and `div_lock`=0.
  - The target channel keeps its old settings until its cnt == r_old−1.
  - In the next cycle the new settings become active, that channel's cnt=0, and the FSM moves to SETTLE.
  - Phase is not applied here; it takes effect at the next ALIGN.
  - Other channels are unaffected throughout.
- `load_phase`:
  - In SETTLE or LOCKED it moves the FSM to ALIGN.
  - In PEND it is ignored.
  - In LOCKED with a simultaneous handshake, the accepted settings are written directly into the active registers, and the ALIGN that follows uses them.
- `rst`:
  - Valid in any state; takes effect at the next edge.
  - Active registers reload INIT_*.
  - Any pending request is discarded.
  - FSM is held in ALIGN while `rst` is high.

## Timing
- Reset values: `clk_en`=0, `clk_lvl`=0, `div_lock`=0, `cfg_ready`=0.
- Start-up sequence:
  - Let c0 be the first cycle with `rst` low; c0 = ALIGN.
  - Counters first run in c1. A phase-0 channel pulses `clk_en` in c1.
  - SETTLE spans c1..c_LOCK_CYCLES.
  - `div_lock` and `cfg_ready` are high from c(LOCK_CYCLES+1).
- `cfg_ready` and `div_lock` are registered outputs and fall in the cycle after an accepted handshake.
- Apply latency: 1 cycle after the target channel's last old-period cycle. With r_old=1 the new settings apply in the cycle after acceptance.
- `div_lock` reasserts LOCK_CYCLES cycles after the first SETTLE cycle, whether that SETTLE follows an apply or a realign.
- Counters, compare and preload are DIV_W bits wide. r−p never underflows because p < r is guaranteed.

## Test plan
- Reset release with defaults:
  - `clk_en`[4:0] pulses at c1, c6, c11.
  - `clk_lvl` is high in c1–c2 and c6–c7.
  - `div_lock`=1 from c17.
- In LOCKED, reconfigure ch2 (ratio 8, duty 4) mid-period:
  - `div_lock` drops in the next cycle.
  - ch2 finishes its ratio-5 period, then pulses every 8 cycles with 4 cycles high.
  - `div_lock` returns 16 cycles after apply.
  - ch0, ch1, ch3 and ch4 are unchanged.
- Set ch1 phase=3 (ratio 5), then pulse `load_phase` with ALIGN at cycle A:
  - ch0 `clk_en` at A+1.
  - ch1 `clk_en` at A+4, A+9.
- Boundary settings:
  - ratio 0, duty 1: `clk_en` and `clk_lvl` constantly 1.
  - ratio 4, duty 9: `clk_lvl` always high.
  - ratio 4, duty 0: `clk_lvl` always low.
  - ratio 4, phase 7 (treated as 3): first pulse at A+4.
- `load_phase` with a simultaneous ch3 handshake (ratio 6) in LOCKED:
  - ALIGN uses ratio 6 for ch3.
  - `clk_en`[3] pulses at A+1 and A+7.
- `rst` asserted while in PEND:
  - All outputs are 0 in the next cycle.
  - After release, every channel restarts with INIT settings.
  - The pending ratio is never applied.
